// File: rtl/usr8_tx_ctrl.sv
// Byte serializer sequencing an external 8-bit universal shift register.
// Optional macro USR_TX_PARITY_EN appends an even-parity bit per byte.
module usr8_tx_ctrl #(
  parameter int   WIDTH = 8,
  parameter int   CNT_W = 4,
  parameter logic FILL  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_msb_first,
  output logic [1:0]       usr_select,
  output logic [WIDTH-1:0] usr_pload,
  output logic             usr_l_in,
  output logic             usr_r_in,
  input  logic [WIDTH-1:0] usr_q,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
`ifdef USR_TX_PARITY_EN
    S_SHIFT,
    S_PARITY
`else
    S_SHIFT
`endif
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pload_q, pload_d;
  logic             msb_q, msb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sel_q, sel_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             cnt_end;

  // Only the two end bits of the USR are ever observed.
  logic unused_q_mid;
  assign unused_q_mid = ^usr_q[WIDTH-2:1];

  assign cnt_end = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    pload_d = pload_q;
    msb_d   = msb_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          pload_d = in_data;
          msb_d   = in_msb_first;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (cnt_end) begin
          cnt_d = '0;
`ifdef USR_TX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_IDLE;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef USR_TX_PARITY_EN
      S_PARITY: state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Registered handshake/select follow the next state.
  always_comb begin
    sel_d   = 2'b00;
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
    unique case (1'b1)
      (state_d == S_LOAD):  sel_d = 2'b11;
      (state_d == S_SHIFT): sel_d = msb_d ? 2'b10 : 2'b01;
      default:              sel_d = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pload_q <= '0;
      msb_q   <= 1'b0;
      cnt_q   <= '0;
      sel_q   <= 2'b00;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pload_q <= pload_d;
      msb_q   <= msb_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    ser_out   = 1'b0;
    ser_valid = 1'b0;
    ser_last  = 1'b0;
    unique case (state_q)
      S_SHIFT: begin
        ser_valid = 1'b1;
        ser_out   = msb_q ? usr_q[WIDTH-1] : usr_q[0];
`ifndef USR_TX_PARITY_EN
        ser_last  = cnt_end;
`endif
      end
`ifdef USR_TX_PARITY_EN
      S_PARITY: begin
        ser_valid = 1'b1;
        ser_out   = ^pload_q;
        ser_last  = 1'b1;
      end
`endif
      default: begin
        ser_valid = 1'b0;
      end
    endcase
  end

  assign in_ready   = ready_q;
  assign busy       = busy_q;
  assign usr_select = sel_q;
  assign usr_pload  = pload_q;
  assign usr_l_in   = FILL;
  assign usr_r_in   = FILL;

endmodule
